// File: rtl/gray_codec_if.sv
// Handshake bundle for gray_codec: producer-side input channel and consumer-side output channel.
// The slave modport is the converter; the master modport is whoever drives and drains it.
interface gray_codec_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_dir;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_dir;
    logic             adj_err;

    modport master (
        output in_valid, in_dir, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_dir, adj_err
    );

    modport slave (
        input  in_valid, in_dir, in_data, out_ready,
        output in_ready, out_valid, out_data, out_dir, adj_err
    );
endinterface

// File: rtl/gray_codec.sv
// Bidirectional binary/Gray converter with a 2-entry output buffer and a
// Gray-sequence adjacency checker on the Gray->binary direction.
module gray_codec #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    gray_codec_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t      r_state;
    logic [WIDTH-1:0] r_mem_data [2];
    logic             r_mem_dir  [2];
    logic             r_mem_err  [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [WIDTH-1:0] r_hist;
    logic             r_hist_vld;

    logic [WIDTH-1:0] w_b2g;
    logic [WIDTH-1:0] w_g2b;
    logic [WIDTH-1:0] w_conv;
    logic [WIDTH-1:0] w_diff;
    logic             w_one_bit;
    logic             w_adj_err;
    logic             w_push;
    logic             w_pop;

    assign w_b2g = bus.in_data ^ (bus.in_data >> 1);

    // Each binary bit is the XOR of all Gray bits at and above it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign w_g2b[gi] = ^(bus.in_data >> gi);
        end
    endgenerate

    assign w_conv = bus.in_dir ? w_g2b : w_b2g;

    // Exactly one bit differs when diff is nonzero and a power of two.
    assign w_diff    = bus.in_data ^ r_hist;
    assign w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - WIDTH'(1))) == '0);
    assign w_adj_err = bus.in_dir && r_hist_vld && !clr && !w_one_bit;

    assign bus.in_ready  = (r_state != ST_FULL);
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_data  = r_mem_data[r_rd_ptr];
    assign bus.out_dir   = r_mem_dir[r_rd_ptr];
    assign bus.adj_err   = r_mem_err[r_rd_ptr];

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_hist     <= '0;
            r_hist_vld <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem_data[i] <= '0;
                r_mem_dir[i]  <= 1'b0;
                r_mem_err[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_conv;
                r_mem_dir[r_wr_ptr]  <= bus.in_dir;
                r_mem_err[r_wr_ptr]  <= w_adj_err;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case (r_state)
                ST_EMPTY: if (w_push) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_push && !w_pop)      r_state <= ST_FULL;
                    else if (!w_push && w_pop) r_state <= ST_EMPTY;
                end
                ST_FULL:  if (w_pop) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase

            // A Gray transfer in the same cycle as clr becomes the fresh history.
            if (w_push && bus.in_dir) begin
                r_hist     <= bus.in_data;
                r_hist_vld <= 1'b1;
            end else if (clr) begin
                r_hist_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gray_codec.sv
// Directed bench for gray_codec: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_gray_codec;
    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    gray_codec_if #(.WIDTH(4)) bus4 ();
    gray_codec_if #(.WIDTH(8)) bus8 ();

    gray_codec #(.WIDTH(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus4)
    );

    gray_codec #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] d;
        logic       dir;
        logic       err;
    } entry_t;

    entry_t     m_q[$];
    logic [3:0] m_hist;
    logic       m_hist_vld;
    bit         m_live = 0;

    function automatic logic [3:0] m_gray_to_bin(input logic [3:0] g);
        logic [3:0] res = '0;
        for (int v = 0; v < 16; v++) begin
            if (4'(v ^ (v >> 1)) == g) res = 4'(v);
        end
        return res;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_hist     = '0;
            m_hist_vld = 1'b0;
            m_live     = 1;
        end else if (m_live) begin
            bit     do_pop;
            bit     do_push;
            entry_t e;
            do_pop  = (m_q.size() != 0) && bus4.out_ready;
            do_push = bus4.in_valid && (m_q.size() != 2);
            if (do_push) begin
                e.dir = bus4.in_dir;
                if (bus4.in_dir) begin
                    e.d   = m_gray_to_bin(bus4.in_data);
                    e.err = m_hist_vld && !clr && ($countones(bus4.in_data ^ m_hist) != 1);
                end else begin
                    e.d   = bus4.in_data ^ (bus4.in_data >> 1);
                    e.err = 1'b0;
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(e);
                if (bus4.in_dir) begin
                    m_hist     = bus4.in_data;
                    m_hist_vld = 1'b1;
                end
            end
            if (clr && !(do_push && bus4.in_dir)) m_hist_vld = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("mdl_out_valid", 32'(bus4.out_valid), 32'(m_q.size() != 0));
            chk("mdl_in_ready", 32'(bus4.in_ready), 32'(m_q.size() != 2));
            if (m_q.size() != 0 && bus4.out_valid) begin
                chk("mdl_out_data", 32'(bus4.out_data), 32'(m_q[0].d));
                chk("mdl_out_dir", 32'(bus4.out_dir), 32'(m_q[0].dir));
                chk("mdl_adj_err", 32'(bus4.adj_err), 32'(m_q[0].err));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic dir, input logic [3:0] d, input logic c);
        bus4.in_valid = 1'b1;
        bus4.in_dir   = dir;
        bus4.in_data  = d;
        clr           = c;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        clr           = 1'b0;
    endtask

    task automatic expect_head(input string nm, input logic [3:0] d, input logic e);
        chk({nm, "_valid"}, 32'(bus4.out_valid), 32'd1);
        chk({nm, "_data"}, 32'(bus4.out_data), 32'(d));
        chk({nm, "_err"}, 32'(bus4.adj_err), 32'(e));
    endtask

    initial begin
        rst_n          = 1'b0;
        clr            = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.in_dir    = 1'b1;
        bus4.in_data   = 4'd5;
        bus4.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_dir    = 1'b0;
        bus8.in_data   = '0;
        bus8.out_ready = 1'b1;

        // Reset held two cycles with traffic and clr asserted
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
            chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);
            chk("rst_adj_err", 32'(bus4.adj_err), 32'd0);
            chk("rst_out_data", 32'(bus4.out_data), 32'd0);
        end
        rst_n         = 1'b1;
        clr           = 1'b0;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_empty", 32'(bus4.out_valid), 32'd0);

        // Binary -> Gray, back-to-back
        send(1'b0, 4'd3, 1'b0);  expect_head("b2g_3", 4'b0010, 1'b0);
        send(1'b0, 4'd7, 1'b0);  expect_head("b2g_7", 4'b0100, 1'b0);
        send(1'b0, 4'd15, 1'b0); expect_head("b2g_15", 4'b1000, 1'b0);
        chk("b2g_dir", 32'(bus4.out_dir), 32'd0);

        // Gray -> binary with adjacency tracking
        send(1'b1, 4'b0010, 1'b0); expect_head("g2b_0010", 4'b0011, 1'b0);
        chk("g2b_dir", 32'(bus4.out_dir), 32'd1);
        send(1'b1, 4'b0110, 1'b0); expect_head("g2b_0110", 4'b0100, 1'b0);
        send(1'b1, 4'b0101, 1'b0); expect_head("g2b_0101", 4'b0110, 1'b1);
        send(1'b1, 4'b0101, 1'b0); expect_head("g2b_repeat", 4'b0110, 1'b1);

        // Wrap-around and clr
        send(1'b1, 4'b1000, 1'b0); expect_head("wrap_1000", 4'b1111, 1'b1);
        send(1'b1, 4'b0000, 1'b0); expect_head("wrap_0000", 4'b0000, 1'b0);
        send(1'b1, 4'b0000, 1'b0); expect_head("same_0000", 4'b0000, 1'b1);
        send(1'b1, 4'b0000, 1'b1); expect_head("clr_0000", 4'b0000, 1'b0);
        send(1'b0, 4'b1111, 1'b0); expect_head("b2g_no_hist", 4'b1000, 1'b0);
        send(1'b1, 4'b0001, 1'b0); expect_head("hist_kept", 4'b0001, 1'b0);
        @(negedge clk);

        // WIDTH=8 instance
        bus8.in_valid = 1'b1;
        bus8.in_dir   = 1'b0;
        bus8.in_data  = 8'hFF;
        @(negedge clk);
        bus8.in_dir   = 1'b1;
        bus8.in_data  = 8'h80;
        chk("w8_b2g_valid", 32'(bus8.out_valid), 32'd1);
        chk("w8_b2g_data", 32'(bus8.out_data), 32'h80);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        chk("w8_g2b_data", 32'(bus8.out_data), 32'hFF);
        chk("w8_g2b_err", 32'(bus8.adj_err), 32'd0);
        @(negedge clk);
        chk("w8_drained", 32'(bus8.out_valid), 32'd0);

        // Backpressure: A, B accepted; C held until space frees
        bus4.out_ready = 1'b0;
        send(1'b0, 4'd3, 1'b0); expect_head("bp_a", 4'd2, 1'b0);
        send(1'b0, 4'd7, 1'b0); expect_head("bp_a_held", 4'd2, 1'b0);
        chk("bp_full_ready", 32'(bus4.in_ready), 32'd0);
        bus4.in_valid = 1'b1;
        bus4.in_dir   = 1'b0;
        bus4.in_data  = 4'd15;
        repeat (2) begin
            @(negedge clk);
            chk("bp_c_held", 32'(bus4.in_ready), 32'd0);
            expect_head("bp_stable", 4'd2, 1'b0);
        end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        expect_head("bp_out_b", 4'd4, 1'b0);
        chk("bp_ready_again", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        expect_head("bp_out_c", 4'd8, 1'b0);
        @(negedge clk);
        chk("bp_drained", 32'(bus4.out_valid), 32'd0);

        // Reset mid-operation with a full buffer
        bus4.out_ready = 1'b0;
        send(1'b1, 4'b0001, 1'b0);
        send(1'b1, 4'b0011, 1'b0);
        chk("mid_full", 32'(bus4.in_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(bus4.out_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus4.in_ready), 32'd1);
        bus4.out_ready = 1'b1;
        send(1'b1, 4'b0110, 1'b0); expect_head("mid_rst_hist", 4'b0100, 1'b0);
        repeat (3) @(negedge clk);
        chk("end_empty", 32'(bus4.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_codec.md
# gray_codec

Parametrised, bidirectional Gray-code converter with valid/ready handshaking, a 2-entry output buffer and a Gray-sequence adjacency checker. It succeeds the fixed 4-bit binary-to-Gray coder. It sits between counter/pointer producers and consumers such as CDC pointer paths and encoder logic. Each transaction selects binary→Gray or Gray→binary independently. The consumer can apply backpressure without losing or duplicating data.

## Interface
- WIDTH, 4, data width in bits (≥2)
- clk  in  1  rising-edge clock; all state updates on this edge
- rst_n  in  1  synchronous reset, active-low
- clr  in  1  clears adjacency history (synchronous, active-high)
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at clk edge
- in_dir  in  1  0 = binary→Gray, 1 = Gray→binary
- in_data  in  WIDTH  value to convert
- out_valid  out  1  out_data/out_dir/adj_err valid
- out_ready  in  1  consumer accepts; pop when out_valid && out_ready at clk edge
- out_data  out  WIDTH  converted value
- out_dir  out  1  echo of in_dir for this transaction
- adj_err  out  1  Gray adjacency violation flag for this transaction

## Operation
- Conversion of each accepted transaction:
  - in_dir=0: out = in ^ (in >> 1).
  - in_dir=1: out[WIDTH-1] = in[WIDTH-1]; out[i] = out[i+1] ^ in[i] for i below.
  - Result, in_dir and adj_err are written as one entry into a 2-entry FIFO.
- FIFO states: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle (legal in ONE only): count unchanged, order preserved.
- in_ready = (count != 2). It is a function of state only, with no combinational path from out_ready.
- out_valid = (count != 0). out_* always present the oldest entry.
- Adjacency history: registers hist[WIDTH-1:0] and hist_vld.
  - Updated only by accepted in_dir=1 transactions: hist ← in_data, hist_vld ← 1.
  - adj_err = hist_vld && (popcount(in_data ^ hist) != 1). Both identical values and multi-bit changes flag an error.
  - Wrap-around (e.g. 1000→0000 at WIDTH=4) is a single-bit change and is not an error.
  - in_dir=0 transactions: adj_err=0; history untouched.
- clr:
  - clr=1 sets hist_vld ← 0.
  - If an in_dir=1 transfer occurs in the same cycle, that transfer sees hist_vld=0 (adj_err=0) and then becomes the new history (hist_vld=1).
  - clr does not affect FIFO contents.
- Backpressure: while FULL, in_ready=0. A held input is not consumed and does not update history.

## Timing
- Reset, when rst_n=0 at an edge:
  - count←0, out_valid=0, in_ready=1 from the next cycle.
  - out_data=0, out_dir=0, adj_err=0.
  - hist=0, hist_vld=0.
  - Reset overrides clr and any same-cycle transfers.
- Reset mid-operation discards all buffered entries; nothing appears on the output afterwards.
- Latency: accepted at edge N → visible with out_valid=1 after edge N (cycle N+1). No combinational in→out path.
- Throughput: 1 transaction/cycle sustained while out_ready=1.
- out_data, out_dir and adj_err remain stable while out_valid=1 && out_ready=0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and clr=1 → out_valid=0, in_ready=1, adj_err=0, and no entry is accepted.
- Binary→Gray, WIDTH=4: send 3, 7, 15 back-to-back with out_ready=1 → out_data 0010, 0100, 1000 one cycle after each accept, adj_err=0. Repeat at WIDTH=8: 8'hFF → 8'h80.
- Gray→binary with adjacency: send 0010, 0110, 0101 → out_data 0011, 0100, 0110 with adj_err 0, 0, 1 (0110→0101 changes 2 bits). A repeated 0101 → adj_err=1.
- Wrap and clr: send Gray 1000 then 0000 → adj_err=0. Send 0000 again → adj_err=1. Assert clr in the same cycle as another 0000 → adj_err=0.
- Backpressure: out_ready=0, offer A=3, B=7, C=15 (binary→Gray) →
  - A and B accepted; in_ready=0 after B; C held.
  - Raise out_ready → outputs 2, 4, 8 in order, with no loss or duplication.
- Reset mid-operation: FIFO FULL, then pulse rst_n=0 for one edge → next cycle out_valid=0, in_ready=1. The next Gray input reports adj_err=0.
